// File: rtl/mailbox.sv
// Receive-side message mailbox: circular buffer feeding a single writeback holding register.
// Optional same-cycle enqueue-to-dequeue bypass: define XCTCMSG_MAILBOX_BYPASS_EN.
module mailbox #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int PT_W   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   loopback_mailbox_valid,
    output logic                                   mailbox_loopback_ready,
    input  logic [ADDR_W+DATA_W-1:0]               loopback_mailbox_data,
    input  logic                                   receive_queue_mailbox_valid,
    output logic                                   mailbox_receive_queue_ready,
    input  logic [REG_W+PT_W-1:0]                  receive_queue_mailbox_data,
    output logic                                   mailbox_writeback_arbiter_valid,
    input  logic                                   writeback_arbiter_mailbox_acknowledge,
    output logic [REG_W+DATA_W+ADDR_W+PT_W-1:0]    mailbox_writeback_arbiter_data,
    output logic [$clog2(DEPTH):0]                 mailbox_occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int MSG_W = ADDR_W + DATA_W;
    localparam int RQ_W  = REG_W + PT_W;
    localparam int WB_W  = REG_W + DATA_W + ADDR_W + PT_W;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    logic [MSG_W-1:0] msg_buf_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] free_ptr_r;
    logic             hold_valid_r;
    logic [WB_W-1:0]  hold_data_r;

    logic [PTR_W-1:0] occupancy_s;
    logic [PTR_W-1:0] pending_s;
    logic             enq_s;
    logic             ack_s;
    logic             alloc_s;
    logic             bypass_s;
    logic             rq_ready_s;
    logic             deq_s;
    logic [MSG_W-1:0] deq_msg_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] free_ptr_nxt_s;
    logic             hold_valid_nxt_s;
    logic [WB_W-1:0]  hold_data_nxt_s;

    // Handshake decode: occupancy, pending count, enqueue/dequeue/acknowledge qualifiers.
    always_comb begin
        occupancy_s = wr_ptr_r - free_ptr_r;
        pending_s   = wr_ptr_r - rd_ptr_r;
        enq_s       = loopback_mailbox_valid & (occupancy_s != PTR_FULL);
        // An acknowledge with nothing held must not free an entry.
        ack_s       = writeback_arbiter_mailbox_acknowledge & hold_valid_r;
        alloc_s     = ~hold_valid_r | writeback_arbiter_mailbox_acknowledge;
`ifdef XCTCMSG_MAILBOX_BYPASS_EN
        bypass_s    = (pending_s == PTR_ZERO) & enq_s & receive_queue_mailbox_valid
                      & alloc_s & ~flush;
`else
        bypass_s    = 1'b0;
`endif
        rq_ready_s  = alloc_s & ~flush & ((pending_s != PTR_ZERO) | bypass_s);
        deq_s       = receive_queue_mailbox_valid & rq_ready_s;
        if (bypass_s) begin
            deq_msg_s = loopback_mailbox_data;
        end else begin
            deq_msg_s = msg_buf_r[rd_ptr_r[IDX_W-1:0]];
        end
    end

    // Next-state computation for pointers and the holding register.
    always_comb begin
        if (enq_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (ack_s) begin
            free_ptr_nxt_s = free_ptr_r + PTR_ONE;
        end else begin
            free_ptr_nxt_s = free_ptr_r;
        end
        hold_data_nxt_s = {receive_queue_mailbox_data[RQ_W-1:PT_W],
                           deq_msg_s[DATA_W-1:0],
                           deq_msg_s[MSG_W-1:DATA_W],
                           receive_queue_mailbox_data[PT_W-1:0]};
        // Flush rewinds the read pointer onto the reserved (unacknowledged) entry.
        if (flush) begin
            rd_ptr_nxt_s     = free_ptr_nxt_s;
            hold_valid_nxt_s = 1'b0;
        end else if (deq_s) begin
            rd_ptr_nxt_s     = rd_ptr_r + PTR_ONE;
            hold_valid_nxt_s = 1'b1;
        end else if (ack_s) begin
            rd_ptr_nxt_s     = rd_ptr_r;
            hold_valid_nxt_s = 1'b0;
        end else begin
            rd_ptr_nxt_s     = rd_ptr_r;
            hold_valid_nxt_s = hold_valid_r;
        end
    end

    // Pointer and holding-valid state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            free_ptr_r   <= PTR_ZERO;
            hold_valid_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            free_ptr_r   <= free_ptr_nxt_s;
            hold_valid_r <= hold_valid_nxt_s;
        end
    end

    // Holding data only changes on a dequeue, so it is stable until acknowledged.
    always_ff @(posedge clk) begin
        if (deq_s) begin
            hold_data_r <= hold_data_nxt_s;
        end
    end

    // Message buffer storage.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            msg_buf_r[wr_ptr_r[IDX_W-1:0]] <= loopback_mailbox_data;
        end
    end

    assign mailbox_loopback_ready          = (occupancy_s != PTR_FULL);
    assign mailbox_receive_queue_ready     = rq_ready_s;
    assign mailbox_writeback_arbiter_valid = hold_valid_r;
    assign mailbox_writeback_arbiter_data  = hold_data_r;
    assign mailbox_occupancy               = occupancy_s;

endmodule
